// File: rtl/oam_dma.sv
// oam_dma -- sprite DMA bus initiator.
//
// A CPU write to TRIG_ADDR starts a transfer. The block halts the CPU, then
// copies 256 bytes from CPU page {page,8'h00} into the PPU OAMDATA register.
// Each byte takes one GET cycle (CPU-bus read) and one PUT cycle (PPU write).
// While halt=1, the top level routes the CPU bus and the PPU register port to
// this block.
//
// Ports
//   clk, rst       clock (one CPU bus cycle) and synchronous active-high reset
//   trig_we/addr/data  CPU write snoop. The data byte is the source page.
//   cpu_rw_i       1 = CPU read cycle. Halt can only take effect on a read.
//   halt           CPU stall / bus ownership
//   mem_rd, mem_addr, mem_data_i  CPU-bus read port. Data arrives one cycle
//                  after mem_rd.
//   ppu_cs_o/rw_o/addr_o/data_o   PPU register port. The PPU acts on the
//                  rising edge of cs.
//   busy           high when the FSM is not idle
//   done           one-cycle pulse after the final PPU write
module oam_dma #(
  parameter logic [15:0] TRIG_ADDR   = 16'h4014,
  parameter logic [2:0]  OAMDATA_REG = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig_we,
  input  logic [15:0] trig_addr,
  input  logic [7:0]  trig_data,
  input  logic        cpu_rw_i,
  output logic        halt,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data_i,
  output logic        ppu_cs_o,
  output logic        ppu_rw_o,
  output logic [2:0]  ppu_addr_o,
  output logic [7:0]  ppu_data_o,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_GET   = 3'd3,
    S_PUT   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] page_q,  page_d;
  logic [7:0] idx_q,   idx_d;
  logic       odd_q;
  logic       done_q,  done_d;

  logic trig_hit;
  assign trig_hit = trig_we && (trig_addr == TRIG_ADDR);

  // odd_q is a free-running parity bit. GET cycles must fall on even cycles,
  // so HALT leaves for GET directly only when the current cycle is odd.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      odd_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      odd_q   <= ~odd_q;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The done cycle is already IDLE, so a trigger in that cycle is accepted.
        if (trig_hit) begin
          page_d  = trig_data;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        // A CPU write cycle cannot be stalled, so hold here until a read cycle.
        if (cpu_rw_i) state_d = odd_q ? S_GET : S_ALIGN;
      end
      S_ALIGN: state_d = S_GET;
      S_GET:   state_d = S_PUT;
      S_PUT: begin
        // idx wraps within 8 bits, so the address never carries into page.
        idx_d = idx_q + 8'd1;
        if (idx_q == 8'hFF) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_GET;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The outputs decode state_q only. cs therefore drops in every GET cycle,
  // and each PUT sees a fresh rising edge.
  always_comb begin
    halt       = (state_q != S_IDLE);
    busy       = (state_q != S_IDLE);
    mem_rd     = 1'b0;
    mem_addr   = 16'h0000;
    ppu_cs_o   = 1'b0;
    ppu_rw_o   = 1'b1;
    ppu_addr_o = 3'd0;
    ppu_data_o = 8'h00;
    done       = done_q;
    case (state_q)
      S_GET: begin
        mem_rd   = 1'b1;
        mem_addr = {page_q, idx_q};
      end
      S_PUT: begin
        ppu_cs_o   = 1'b1;
        ppu_rw_o   = 1'b0;
        ppu_addr_o = OAMDATA_REG;
        ppu_data_o = mem_data_i;  // read data from the preceding GET
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma. Cycle 0 is the first cycle after reset is
// released, and parity is even in that cycle. A negedge monitor records
// counters and timestamps. Each test task compares those records against
// hand-computed values.
module tb_oam_dma;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig_we = 1'b0;
  logic [15:0] trig_addr = 16'h0000;
  logic [7:0]  trig_data = 8'h00;
  logic        cpu_rw_i = 1'b1;
  logic        halt, mem_rd, ppu_cs_o, ppu_rw_o, busy, done;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_i = 8'h00;
  logic [2:0]  ppu_addr_o;
  logic [7:0]  ppu_data_o;

  oam_dma dut (
    .clk(clk), .rst(rst), .trig_we(trig_we), .trig_addr(trig_addr),
    .trig_data(trig_data), .cpu_rw_i(cpu_rw_i), .halt(halt), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_data_i(mem_data_i), .ppu_cs_o(ppu_cs_o),
    .ppu_rw_o(ppu_rw_o), .ppu_addr_o(ppu_addr_o), .ppu_data_o(ppu_data_o),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Memory model: the byte at an address is addr[7:0]^5A. It is returned the
  // cycle after mem_rd.
  always @(posedge clk) if (mem_rd) mem_data_i <= mem_addr[7:0] ^ 8'h5A;

  // Monitor
  logic        mon_clr = 1'b0;
  logic [7:0]  mon_page = 8'h00;
  int halt_cnt, halt_first, halt_last, first_get, first_cs, last_rd_cyc;
  int rd_cnt, rd_err, page_err, wr_cnt, wr_err, viol, done_cnt, done_cyc;
  logic [15:0] first_rd_addr, last_rd_addr;
  logic [7:0]  first_cs_data;
  logic        cs_prev;

  always @(negedge clk) begin
    if (mon_clr) begin
      halt_cnt <= 0; halt_first <= -1; halt_last <= -1; first_get <= -1;
      first_cs <= -1; last_rd_cyc <= -1; rd_cnt <= 0; rd_err <= 0; page_err <= 0;
      wr_cnt <= 0; wr_err <= 0; viol <= 0; done_cnt <= 0; done_cyc <= -1;
      first_rd_addr <= 16'h0; last_rd_addr <= 16'h0; first_cs_data <= 8'h0;
      cs_prev <= 1'b0;
    end else begin
      if (halt) begin
        halt_cnt <= halt_cnt + 1;
        if (halt_first < 0) halt_first <= cyc;
        halt_last <= cyc;
      end
      if (mem_rd) begin
        if (first_get < 0) begin first_get <= cyc; first_rd_addr <= mem_addr; end
        if (mem_addr[7:0] !== rd_cnt[7:0]) rd_err <= rd_err + 1;
        if (mem_addr[15:8] !== mon_page) page_err <= page_err + 1;
        rd_cnt <= rd_cnt + 1;
        last_rd_addr <= mem_addr;
        last_rd_cyc <= cyc;
      end
      if (ppu_cs_o) begin
        if (cs_prev || ppu_rw_o !== 1'b0 || ppu_addr_o !== 3'd4 || mem_rd) viol <= viol + 1;
        if (first_cs < 0) begin first_cs <= cyc; first_cs_data <= ppu_data_o; end
        if (ppu_data_o !== (wr_cnt[7:0] ^ 8'h5A)) wr_err <= wr_err + 1;
        wr_cnt <= wr_cnt + 1;
      end else if (ppu_rw_o !== 1'b1 || ppu_data_o !== 8'h00) begin
        viol <= viol + 1;
      end
      if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      cs_prev <= ppu_cs_o;
    end
  end

  int pass = 0;
  int chk  = 0;

  task automatic wait_cyc(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1; @(negedge clk); #1; mon_clr = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; trig_we = 1'b0; cpu_rw_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clr_mon();
  endtask

  task automatic cpu_write(input int at, input logic [15:0] a, input logic [7:0] d);
    wait_cyc(at);
    trig_we = 1'b1; trig_addr = a; trig_data = d;
    @(posedge clk); #1;
    trig_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk++; if (halt !== 1'b0)        $display("FAIL reset_halt got %b want 0", halt); else pass++;
    chk++; if (mem_rd !== 1'b0)      $display("FAIL reset_mem_rd got %b want 0", mem_rd); else pass++;
    chk++; if (mem_addr !== 16'h0)   $display("FAIL reset_mem_addr got %h want 0000", mem_addr); else pass++;
    chk++; if (ppu_cs_o !== 1'b0)    $display("FAIL reset_cs got %b want 0", ppu_cs_o); else pass++;
    chk++; if (ppu_rw_o !== 1'b1)    $display("FAIL reset_rw got %b want 1", ppu_rw_o); else pass++;
    chk++; if (ppu_addr_o !== 3'd0)  $display("FAIL reset_paddr got %0d want 0", ppu_addr_o); else pass++;
    chk++; if (ppu_data_o !== 8'h00) $display("FAIL reset_pdata got %h want 00", ppu_data_o); else pass++;
    chk++; if (busy !== 1'b0)        $display("FAIL reset_busy got %b want 0", busy); else pass++;
    chk++; if (done !== 1'b0)        $display("FAIL reset_done got %b want 0", done); else pass++;
  endtask

  // Trigger in an even cycle, so no ALIGN cycle is needed. A write to another
  // address is ignored.
  task automatic test_aligned();
    apply_reset(); mon_page = 8'h02;
    cpu_write(5, 16'h4015, 8'h02);
    cpu_write(10, 16'h4014, 8'h02);
    wait_cyc(530);
    chk++; if (halt_first !== 11)  $display("FAIL al_halt_first got %0d want 11", halt_first); else pass++;
    chk++; if (halt_last !== 523)  $display("FAIL al_halt_last got %0d want 523", halt_last); else pass++;
    chk++; if (halt_cnt !== 513)   $display("FAIL al_halt_cnt got %0d want 513", halt_cnt); else pass++;
    chk++; if (first_get !== 12)   $display("FAIL al_first_get got %0d want 12", first_get); else pass++;
    chk++; if (first_rd_addr !== 16'h0200) $display("FAIL al_first_addr got %h want 0200", first_rd_addr); else pass++;
    chk++; if (first_cs !== 13)    $display("FAIL al_first_cs got %0d want 13", first_cs); else pass++;
    chk++; if (first_cs_data !== 8'h5A) $display("FAIL al_first_data got %h want 5a", first_cs_data); else pass++;
    chk++; if (last_rd_addr !== 16'h02FF || last_rd_cyc !== 522)
      $display("FAIL al_last_rd got %h@%0d want 02ff@522", last_rd_addr, last_rd_cyc); else pass++;
    chk++; if (done_cyc !== 524 || done_cnt !== 1)
      $display("FAIL al_done got cyc %0d cnt %0d want 524/1", done_cyc, done_cnt); else pass++;
    chk++; if (wr_cnt !== 256 || wr_err !== 0)
      $display("FAIL al_writes got cnt %0d err %0d want 256/0", wr_cnt, wr_err); else pass++;
    chk++; if (rd_err !== 0 || page_err !== 0 || viol !== 0)
      $display("FAIL al_protocol got rd %0d page %0d viol %0d want 0/0/0", rd_err, page_err, viol); else pass++;
    chk++; if (busy !== 1'b0)      $display("FAIL al_busy_end got %b want 0", busy); else pass++;
  endtask

  // Trigger in an odd cycle, which adds one ALIGN cycle.
  task automatic test_align();
    apply_reset(); mon_page = 8'h02;
    cpu_write(11, 16'h4014, 8'h02);
    wait_cyc(532);
    chk++; if (halt_first !== 12 || halt_last !== 525 || halt_cnt !== 514)
      $display("FAIL align_halt got %0d..%0d n=%0d want 12..525 n=514", halt_first, halt_last, halt_cnt); else pass++;
    chk++; if (first_get !== 14)   $display("FAIL align_first_get got %0d want 14", first_get); else pass++;
    chk++; if (done_cyc !== 526)   $display("FAIL align_done got %0d want 526", done_cyc); else pass++;
    chk++; if (wr_cnt !== 256 || wr_err !== 0 || viol !== 0)
      $display("FAIL align_writes got cnt %0d err %0d viol %0d want 256/0/0", wr_cnt, wr_err, viol); else pass++;
  endtask

  // The CPU is on write cycles during the first two HALT cycles.
  task automatic test_write_hold();
    apply_reset(); mon_page = 8'h02;
    wait_cyc(10); cpu_rw_i = 1'b0;
    cpu_write(10, 16'h4014, 8'h02);
    wait_cyc(13); cpu_rw_i = 1'b1;
    wait_cyc(532);
    chk++; if (halt_first !== 11 || halt_cnt !== 515)
      $display("FAIL hold_halt got first %0d n=%0d want 11 n=515", halt_first, halt_cnt); else pass++;
    chk++; if (first_get !== 14)   $display("FAIL hold_first_get got %0d want 14", first_get); else pass++;
    chk++; if (done_cyc !== 526 || wr_cnt !== 256)
      $display("FAIL hold_done got %0d wr %0d want 526/256", done_cyc, wr_cnt); else pass++;
  endtask

  // Source page FF. A retrigger in the middle of the transfer is ignored.
  task automatic test_page_ff();
    apply_reset(); mon_page = 8'hFF;
    cpu_write(10, 16'h4014, 8'hFF);
    cpu_write(100, 16'h4014, 8'h03);
    wait_cyc(530);
    chk++; if (page_err !== 0 || rd_err !== 0 || rd_cnt !== 256)
      $display("FAIL ff_reads got page_err %0d idx_err %0d n %0d want 0/0/256", page_err, rd_err, rd_cnt); else pass++;
    chk++; if (first_rd_addr !== 16'hFF00 || last_rd_addr !== 16'hFFFF)
      $display("FAIL ff_span got %h..%h want ff00..ffff", first_rd_addr, last_rd_addr); else pass++;
    chk++; if (wr_cnt !== 256 || done_cnt !== 1 || done_cyc !== 524)
      $display("FAIL ff_count got wr %0d done %0d@%0d want 256 1@524", wr_cnt, done_cnt, done_cyc); else pass++;
  endtask

  // A trigger in the same cycle as done starts a second transfer.
  task automatic test_back_to_back();
    apply_reset(); mon_page = 8'h01;
    cpu_write(10, 16'h4014, 8'h01);
    cpu_write(524, 16'h4014, 8'h04);
    wait_cyc(1045);
    chk++; if (done_cnt !== 2 || done_cyc !== 1038)
      $display("FAIL b2b_done got %0d@%0d want 2@1038", done_cnt, done_cyc); else pass++;
    chk++; if (wr_cnt !== 512 || wr_err !== 0 || rd_err !== 0 || viol !== 0)
      $display("FAIL b2b_writes got wr %0d err %0d rd %0d viol %0d want 512/0/0/0", wr_cnt, wr_err, rd_err, viol); else pass++;
    chk++; if (last_rd_addr !== 16'h04FF || halt_cnt !== 1026)
      $display("FAIL b2b_tail got %h halt %0d want 04ff 1026", last_rd_addr, halt_cnt); else pass++;
  endtask

  // Reset is asserted during PUT #100 (cycle 211), then a fresh transfer runs.
  task automatic test_rst_mid();
    apply_reset(); mon_page = 8'h02;
    cpu_write(10, 16'h4014, 8'h02);
    wait_cyc(211);
    rst = 1'b1;
    @(negedge clk);
    chk++; if (ppu_cs_o !== 1'b1 || ppu_data_o !== 8'h39)
      $display("FAIL rst_put100 got cs %b data %h want 1 39", ppu_cs_o, ppu_data_o); else pass++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk++; if ({halt, mem_rd, mem_addr, ppu_cs_o, ppu_rw_o, ppu_addr_o, ppu_data_o, busy, done}
               !== {1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 3'd0, 8'h0, 1'b0, 1'b0})
      $display("FAIL rst_outputs got halt %b rd %b addr %h cs %b rw %b pa %0d pd %h busy %b done %b",
               halt, mem_rd, mem_addr, ppu_cs_o, ppu_rw_o, ppu_addr_o, ppu_data_o, busy, done); else pass++;
    wait_cyc(40);
    chk++; if (wr_cnt !== 100 || done_cnt !== 0)
      $display("FAIL rst_quiet got wr %0d done %0d want 100/0", wr_cnt, done_cnt); else pass++;
    clr_mon();
    cpu_write(50, 16'h4014, 8'h02);
    wait_cyc(570);
    chk++; if (first_rd_addr !== 16'h0200 || first_get !== 52)
      $display("FAIL rst_restart got %h@%0d want 0200@52", first_rd_addr, first_get); else pass++;
    chk++; if (wr_cnt !== 256 || wr_err !== 0 || done_cyc !== 564)
      $display("FAIL rst_full got wr %0d err %0d done %0d want 256/0/564", wr_cnt, wr_err, done_cyc); else pass++;
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_align();
    test_write_hold();
    test_page_ff();
    test_back_to_back();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
